// File: rtl/activation_unit.sv
// -----------------------------------------------------------------------------
// activation_unit
//
// Streams len elements from an input memory, applies an element-wise
// activation function and writes each result to an output memory at the
// same index. One element is processed every RD_LAT+1 cycles.
//
// Optional feature macro: ACT_CLAMP_EN
//   defined   : mode 3 clamps to [0, clamp_max] (signed compare)
//   undefined : mode 3 behaves as ReLU and clamp_max is ignored
//
// Parameters
//   DATA_W     element width (signed two's complement)
//   ADDR_W     memory address width
//   LEN_W      element-count width
//   RD_LAT     input-memory read latency in cycles (1..4)
//   LEAK_SHIFT arithmetic right shift applied to negatives in leaky mode
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        one-cycle request to begin a pass (ignored while busy)
//   mode         0=ReLU, 1=leaky ReLU, 2=pass-through, 3=clamp
//   len          number of elements to process
//   clamp_max    upper bound for clamp mode
//   input_addr   read address (held for the whole fetch of one element)
//   input_data   read data, valid RD_LAT cycles after input_addr
//   output_addr  write address
//   output_data  write data
//   write_enable one-cycle write strobe
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module activation_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 10,
  parameter int RD_LAT     = 1,
  parameter int LEAK_SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] clamp_max,
  output logic [ADDR_W-1:0] input_addr,
  input  logic [DATA_W-1:0] input_data,
  output logic [ADDR_W-1:0] output_addr,
  output logic [DATA_W-1:0] output_data,
  output logic              write_enable,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_FINISH
  } state_e;

  typedef enum logic [1:0] {
    MODE_RELU  = 2'd0,
    MODE_LEAKY = 2'd1,
    MODE_PASS  = 2'd2,
    MODE_CLAMP = 2'd3
  } mode_e;

  // WAIT spends RD_LAT-1 cycles; the counter value on its final cycle.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    i_q, i_d;
  logic [1:0]          wait_q, wait_d;
  mode_e               mode_q, mode_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

`ifdef ACT_CLAMP_EN
  logic [DATA_W-1:0]   clamp_q, clamp_d;
`else
  // clamp_max has no function in this build.
  logic                unused_clamp;
  assign unused_clamp = ^clamp_max;
`endif

  // ---------------------------------------------------------------------------
  // Activation function applied to the sample arriving this cycle.
  // ---------------------------------------------------------------------------
  logic              x_neg;
  logic [DATA_W-1:0] leaky_x;
  logic [DATA_W-1:0] act_y;

  assign x_neg   = input_data[DATA_W-1];
  // Arithmetic shift floors toward minus infinity, e.g. -9 >>> 3 = -2.
  assign leaky_x = $signed(input_data) >>> LEAK_SHIFT;

  always_comb begin
    act_y = input_data;
    case (mode_q)
      MODE_RELU:  act_y = x_neg ? '0 : input_data;
      MODE_LEAKY: act_y = x_neg ? leaky_x : input_data;
      MODE_PASS:  act_y = input_data;
      default: begin
`ifdef ACT_CLAMP_EN
        if (x_neg)
          act_y = '0;
        else if ($signed(input_data) > $signed(clamp_q))
          act_y = clamp_q;
        else
          act_y = input_data;
`else
        act_y = x_neg ? '0 : input_data;
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    i_d        = i_q;
    wait_d     = wait_q;
    mode_d     = mode_q;
    len_d      = len_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    we_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef ACT_CLAMP_EN
    clamp_d    = clamp_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          len_d   = len;
`ifdef ACT_CLAMP_EN
          clamp_d = clamp_max;
`endif
          i_d     = '0;
          busy_d  = 1'b1;
          state_d = (len == '0) ? S_FINISH : S_FETCH;
        end
      end

      S_FETCH: begin
        wait_d  = '0;
        state_d = (RD_LAT == 1) ? S_WRITE : S_WAIT;
      end

      S_WAIT: begin
        if (wait_q == WAIT_LAST)
          state_d = S_WRITE;
        else
          wait_d = wait_q + 2'd1;
      end

      S_WRITE: begin
        we_d       = 1'b1;
        out_addr_d = ADDR_W'(i_q);
        out_data_d = act_y;
        if (i_q == len_q - LEN_W'(1)) begin
          state_d = S_FINISH;
        end else begin
          i_d     = i_q + LEN_W'(1);
          state_d = S_FETCH;
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge next-state value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      wait_q     <= '0;
      mode_q     <= MODE_RELU;
      len_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ACT_CLAMP_EN
      clamp_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      wait_q     <= wait_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef ACT_CLAMP_EN
      clamp_q    <= clamp_d;
`endif
    end
  end

  // The read address follows the element index; it stays stable from FETCH
  // through WRITE so the memory sees one address per element.
  assign input_addr   = ADDR_W'(i_q);
  assign output_addr  = out_addr_q;
  assign output_data  = out_data_q;
  assign write_enable = we_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
